// File: rtl/riscp_pkg.sv
// Shared definitions for the interrupt context save/restore sequencer:
// FSM state encoding, ALU flag layout and stack word packing.
package riscp_pkg;

    localparam int FLAG_W = 3;
    localparam int FLAG_C = 2;
    localparam int FLAG_N = 1;
    localparam int FLAG_Z = 0;

    typedef enum logic [3:0] {
        IDLE     = 4'd0,
        DRAIN    = 4'd1,
        PUSH_PCH = 4'd2,
        PUSH_PCL = 4'd3,
        PUSH_FLG = 4'd4,
        LOAD_VEC = 4'd5,
        POP_FLG  = 4'd6,
        POP_PCL  = 4'd7,
        POP_PCH  = 4'd8,
        RTI_LOAD = 4'd9
    } ictl_state_t;

    // Flags occupy the low bits of a 16-bit stack word.
    function automatic logic [15:0] flag_word(input logic [FLAG_W-1:0] f);
        return {{(16-FLAG_W){1'b0}}, f};
    endfunction

endpackage

// File: rtl/interrupt_flag_ctrl.sv
// Saves return PC and {C,N,Z} flags on the data stack on interrupt entry and
// restores them on RTI, steering fetch and the ALU flag register meanwhile.
module interrupt_flag_ctrl
    import riscp_pkg::*;
#(
    parameter int          PC_W         = 32,
    parameter logic [31:0] INT_VECTOR   = 32'h0000_0020,
    parameter int          DRAIN_CYCLES = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              int_req,
    input  logic              rti_decoded,
    input  logic [PC_W-1:0]   pc_in,
    input  logic [2:0]        flag_register,
    input  logic [15:0]       mem_rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [15:0]       mem_wdata,
    output logic              stall,
    output logic              flush,
    output logic              pc_load,
    output logic [PC_W-1:0]   pc_load_value,
    output logic              flag_regsel,
    output logic [2:0]        conditions_from_memory_pop,
    output logic              int_ack,
    output logic              busy
);

    ictl_state_t        state_reg;
    ictl_state_t        state_next;
    logic               pending_reg;
    logic [2:0]         drain_cnt_reg;
    logic [PC_W-1:0]    ret_pc_reg;
    logic [FLAG_W-1:0]  saved_flags_reg;
    logic [15:0]        lo_reg;
    logic [15:0]        pc_hi_word;
    logic               take_int;
    logic               drain_last;

    // RTI has priority over a pending interrupt in IDLE.
    assign take_int   = (state_reg == IDLE) && !rti_decoded && pending_reg;
    assign drain_last = (state_reg == DRAIN) &&
                        (drain_cnt_reg == 3'(DRAIN_CYCLES - 1));

    // Upper PC bits zero-extended into a full stack word.
    genvar gi;
    generate
        for (gi = 0; gi < 16; gi++) begin : g_pch
            if (gi < PC_W - 16) begin : g_bit
                assign pc_hi_word[gi] = ret_pc_reg[16 + gi];
            end else begin : g_zero
                assign pc_hi_word[gi] = 1'b0;
            end
        end
    endgenerate

    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            IDLE: begin
                if (rti_decoded) begin
                    state_next = POP_FLG;
                end else if (pending_reg) begin
                    state_next = DRAIN;
                end
            end
            DRAIN:    if (drain_last) state_next = PUSH_PCH;
            PUSH_PCH: state_next = PUSH_PCL;
            PUSH_PCL: state_next = PUSH_FLG;
            PUSH_FLG: state_next = LOAD_VEC;
            LOAD_VEC: state_next = IDLE;
            POP_FLG:  state_next = POP_PCL;
            POP_PCL:  state_next = POP_PCH;
            POP_PCH:  state_next = RTI_LOAD;
            RTI_LOAD: state_next = IDLE;
            default:  state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= IDLE;
            pending_reg     <= 1'b0;
            drain_cnt_reg   <= '0;
            ret_pc_reg      <= '0;
            saved_flags_reg <= '0;
            lo_reg          <= '0;
        end else begin
            state_reg <= state_next;
            // A new request in the same cycle as entry keeps the latch set.
            pending_reg <= int_req | (pending_reg & ~take_int);
            if (take_int) begin
                ret_pc_reg    <= pc_in;
                drain_cnt_reg <= '0;
            end else if (state_reg == DRAIN) begin
                drain_cnt_reg <= drain_cnt_reg + 3'd1;
            end
            if (drain_last) begin
                saved_flags_reg <= flag_register;
            end
            if (state_reg == POP_PCH) begin
                lo_reg <= mem_rdata;
            end
        end
    end

    always_comb begin
        mem_req                    = 1'b0;
        mem_we                     = 1'b0;
        mem_wdata                  = '0;
        pc_load                    = 1'b0;
        pc_load_value              = '0;
        flag_regsel                = 1'b0;
        conditions_from_memory_pop = '0;
        int_ack                    = 1'b0;
        stall                      = (state_reg != IDLE);
        busy                       = (state_reg != IDLE);
        flush                      = (state_reg == IDLE) && pending_reg;
        unique case (state_reg)
            PUSH_PCH: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_wdata = pc_hi_word;
            end
            PUSH_PCL: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_wdata = ret_pc_reg[15:0];
            end
            PUSH_FLG: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_wdata = flag_word(saved_flags_reg);
            end
            LOAD_VEC: begin
                pc_load       = 1'b1;
                pc_load_value = INT_VECTOR[PC_W-1:0];
                int_ack       = 1'b1;
            end
            POP_FLG: mem_req = 1'b1;
            POP_PCL: begin
                // Flags popped by POP_FLG are on the bus now.
                mem_req                    = 1'b1;
                flag_regsel                = 1'b1;
                conditions_from_memory_pop = mem_rdata[FLAG_W-1:0];
            end
            POP_PCH: mem_req = 1'b1;
            RTI_LOAD: begin
                pc_load       = 1'b1;
                pc_load_value = {mem_rdata[PC_W-17:0], lo_reg};
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_interrupt_flag_ctrl.sv
// Self-checking bench: directed scenarios with literal expectations, then
// random requests/RTIs checked every cycle against a transaction-level model.
module tb_interrupt_flag_ctrl;

    localparam int          PC_W = 32;
    localparam logic [31:0] VEC  = 32'h0000_0020;
    localparam int          DC   = 3;

    logic            clk;
    logic            rst_n;
    logic            int_req;
    logic            rti_decoded;
    logic [PC_W-1:0] pc_in;
    logic [2:0]      flag_register;
    logic [15:0]     mem_rdata;
    logic            mem_req;
    logic            mem_we;
    logic [15:0]     mem_wdata;
    logic            stall;
    logic            flush;
    logic            pc_load;
    logic [PC_W-1:0] pc_load_value;
    logic            flag_regsel;
    logic [2:0]      conditions_from_memory_pop;
    logic            int_ack;
    logic            busy;

    interrupt_flag_ctrl #(.PC_W(PC_W), .INT_VECTOR(VEC), .DRAIN_CYCLES(DC)) dut (
        .clk(clk), .rst_n(rst_n), .int_req(int_req), .rti_decoded(rti_decoded),
        .pc_in(pc_in), .flag_register(flag_register), .mem_rdata(mem_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_wdata(mem_wdata),
        .stall(stall), .flush(flush), .pc_load(pc_load),
        .pc_load_value(pc_load_value), .flag_regsel(flag_regsel),
        .conditions_from_memory_pop(conditions_from_memory_pop),
        .int_ack(int_ack), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;

    // Expected outputs for one cycle of a sequence.
    typedef struct {
        logic            stall;
        logic            req;
        logic            we;
        logic [15:0]     wdata;
        logic            use_cap;
        logic            pcl;
        logic [PC_W-1:0] pcv;
        logic            regsel;
        logic [2:0]      cond;
        logic            ack;
        logic            cap;
        logic            is_rti;
    } exp_t;

    exp_t        script[$];
    logic [15:0] mstack[$];
    logic        mpend;
    logic [15:0] cap_word;

    logic        tb_push;
    logic [15:0] tb_push_data;

    function automatic exp_t blank();
        exp_t e;
        e.stall = 1'b0; e.req = 1'b0; e.we = 1'b0; e.wdata = '0; e.use_cap = 1'b0;
        e.pcl = 1'b0; e.pcv = '0; e.regsel = 1'b0; e.cond = '0; e.ack = 1'b0;
        e.cap = 1'b0; e.is_rti = 1'b0;
        return e;
    endfunction

    // Reference model: each accepted event expands into its cycle script.
    initial begin
        exp_t        r;
        logic [15:0] f, lo, hi;
        logic [31:0] rp;
        mpend    = 1'b0;
        cap_word = '0;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                script.delete();
                mstack.delete();
                mpend = 1'b0;
            end else begin
                if (tb_push) mstack.push_front(tb_push_data);
                if (script.size() != 0) begin
                    r = script.pop_front();
                    if (r.cap) begin
                        cap_word = {13'b0, flag_register};
                        mstack.push_front(cap_word);
                    end
                end else if (rti_decoded) begin
                    f  = mstack.pop_front();
                    lo = mstack.pop_front();
                    hi = mstack.pop_front();
                    r = blank(); r.stall = 1; r.req = 1; script.push_back(r);
                    r = blank(); r.stall = 1; r.req = 1; r.regsel = 1; r.cond = f[2:0];
                    script.push_back(r);
                    r = blank(); r.stall = 1; r.req = 1; script.push_back(r);
                    r = blank(); r.stall = 1; r.pcl = 1; r.pcv = PC_W'({hi, lo});
                    r.is_rti = 1; script.push_back(r);
                end else if (mpend) begin
                    mpend = 1'b0;
                    rp = 32'(pc_in);
                    for (int i = 0; i < DC; i++) begin
                        r = blank(); r.stall = 1; r.cap = (i == DC - 1); script.push_back(r);
                    end
                    r = blank(); r.stall = 1; r.req = 1; r.we = 1; r.wdata = rp[31:16];
                    script.push_back(r);
                    r = blank(); r.stall = 1; r.req = 1; r.we = 1; r.wdata = rp[15:0];
                    script.push_back(r);
                    r = blank(); r.stall = 1; r.req = 1; r.we = 1; r.use_cap = 1;
                    script.push_back(r);
                    r = blank(); r.stall = 1; r.pcl = 1; r.pcv = VEC[PC_W-1:0]; r.ack = 1;
                    script.push_back(r);
                    mstack.push_front(rp[31:16]);
                    mstack.push_front(rp[15:0]);
                end
                if (int_req) mpend = 1'b1;
            end
        end
    end

    // Stack memory: push writes then decrements SP; pop increments then reads.
    logic [15:0] mem [0:511];
    int          sp;
    initial begin
        sp = 256;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                sp = 256;
                mem_rdata <= '0;
            end else if (mem_req) begin
                if (mem_we) begin
                    mem[sp & 511] = mem_wdata;
                    sp = sp - 1;
                end else begin
                    sp = sp + 1;
                    mem_rdata <= mem[sp & 511];
                end
            end else if (tb_push) begin
                mem[sp & 511] = tb_push_data;
                sp = sp - 1;
            end
        end
    end

    // Per-cycle compare against the model.
    initial begin
        exp_t e;
        logic ok;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                e = (script.size() != 0) ? script[0] : blank();
                if (e.use_cap) e.wdata = cap_word;
                ok = (stall === e.stall) && (busy === e.stall) &&
                     (flush === ((script.size() == 0) && mpend)) &&
                     (mem_req === e.req) && (!e.req || mem_we === e.we) &&
                     (!(e.req && e.we) || mem_wdata === e.wdata) &&
                     (pc_load === e.pcl) && (!e.pcl || pc_load_value === e.pcv) &&
                     (flag_regsel === e.regsel) &&
                     (!e.regsel || conditions_from_memory_pop === e.cond) &&
                     (int_ack === e.ack);
                checks++;
                if (ok) passes++;
                else $display("FAIL cycle_cmp @%0t: got stall=%b busy=%b flush=%b req=%b we=%b wd=%h pcl=%b pcv=%h rs=%b cond=%b ack=%b; want stall=%b req=%b we=%b wd=%h pcl=%b pcv=%h rs=%b cond=%b ack=%b",
                    $time, stall, busy, flush, mem_req, mem_we, mem_wdata, pc_load, pc_load_value,
                    flag_regsel, conditions_from_memory_pop, int_ack, e.stall, e.req, e.we,
                    e.wdata, e.pcl, e.pcv, e.regsel, e.cond, e.ack);
                if (e.ack) $display("[%0t] interrupt entry, vector %h", $time, e.pcv);
                if (e.is_rti) $display("[%0t] rti return to %h", $time, e.pcv);
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    int lvl;

    initial begin
        rst_n = 1'b0; int_req = 1'b0; rti_decoded = 1'b0;
        pc_in = 32'h0001_0A4C; flag_register = 3'b101;
        tb_push = 1'b0; tb_push_data = '0;
        repeat (3) @(negedge clk);
        chk("reset_outputs", {mem_req, mem_we, mem_wdata, stall, flush, pc_load, pc_load_value,
            flag_regsel, conditions_from_memory_pop, int_ack, busy}, 64'd0);
        #1 rst_n = 1'b1;

        // Reset mid-push.
        @(negedge clk); #1 int_req = 1'b1;
        @(negedge clk); #1 int_req = 1'b0;
        repeat (4) @(negedge clk);
        @(negedge clk);
        chk("in_push_pcl", {mem_req, mem_we, mem_wdata}, {2'b11, 16'h0A4C});
        #1 rst_n = 1'b0;
        #1 chk("async_reset_outputs", {mem_req, mem_we, mem_wdata, stall, flush, pc_load,
            pc_load_value, flag_regsel, conditions_from_memory_pop, int_ack, busy}, 64'd0);
        @(negedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        chk("idle_after_reset", {mem_req, busy}, 2'b00);

        // Prefill the stack so random RTIs have frames to pop.
        for (int i = 0; i < 40; i++) begin
            #1 tb_push = 1'b1; tb_push_data = 16'($urandom);
            @(negedge clk);
        end
        #1 tb_push = 1'b0;

        // Interrupt entry with literal expectations.
        pc_in = 32'h0001_0A4C; flag_register = 3'b101; int_req = 1'b1;
        @(negedge clk); chk("int_flush", {flush, busy}, 2'b10); #1 int_req = 1'b0;
        for (int i = 0; i < DC; i++) begin
            @(negedge clk); chk("drain", {stall, mem_req}, 2'b10);
        end
        @(negedge clk); chk("push_hi", {mem_req, mem_we, mem_wdata}, {2'b11, 16'h0001});
        @(negedge clk); chk("push_lo", {mem_req, mem_we, mem_wdata}, {2'b11, 16'h0A4C});
        @(negedge clk); chk("push_flg", {mem_req, mem_we, mem_wdata}, {2'b11, 16'h0005});
        @(negedge clk); chk("load_vec", {pc_load, int_ack, pc_load_value}, {2'b11, 32'h0000_0020});
        @(negedge clk); chk("int_done", busy, 1'b0);

        // RTI round trip restores the frame just pushed.
        #1 rti_decoded = 1'b1;
        @(negedge clk); chk("pop_flg", {mem_req, mem_we}, 2'b10); #1 rti_decoded = 1'b0;
        @(negedge clk); chk("pop_flags", {flag_regsel, conditions_from_memory_pop}, {1'b1, 3'b101});
        @(negedge clk); chk("pop_pch", {mem_req, flag_regsel}, 2'b10);
        @(negedge clk); chk("rti_pc", {pc_load, int_ack, pc_load_value}, {2'b10, 32'h0001_0A4C});
        @(negedge clk); chk("rti_done", busy, 1'b0);

        // RTI of a known frame, with a request arriving mid-sequence.
        #1 tb_push = 1'b1; tb_push_data = 16'h0002;
        @(negedge clk); #1 tb_push_data = 16'h1234;
        @(negedge clk); #1 tb_push_data = 16'h0006;
        @(negedge clk); #1 tb_push = 1'b0; rti_decoded = 1'b1;
        @(negedge clk); #1 rti_decoded = 1'b0;
        @(negedge clk); chk("pop_flags_110", {flag_regsel, conditions_from_memory_pop}, {1'b1, 3'b110});
        #1 int_req = 1'b1;
        @(negedge clk); chk("regsel_one_cycle", flag_regsel, 1'b0); #1 int_req = 1'b0;
        @(negedge clk); chk("rti_pc_21234", {pc_load, pc_load_value}, {1'b1, 32'h0002_1234});
        @(negedge clk); chk("pending_kept", {flush, busy}, 2'b10);
        @(negedge clk); chk("drain_after_rti", {stall, mem_req}, 2'b10);
        repeat (7) @(negedge clk);
        chk("int2_done", busy, 1'b0);

        // RTI and pending interrupt together: RTI first.
        #1 int_req = 1'b1;
        @(negedge clk); chk("both_flush", flush, 1'b1); #1 int_req = 1'b0; rti_decoded = 1'b1;
        @(negedge clk); chk("rti_wins", {mem_req, mem_we, stall}, 3'b101); #1 rti_decoded = 1'b0;
        repeat (3) @(negedge clk);
        @(negedge clk); chk("int_after_rti", {flush, busy}, 2'b10);
        @(negedge clk); chk("drain_after_both", {stall, mem_req}, 2'b10);
        repeat (7) @(negedge clk);
        chk("int3_done", busy, 1'b0);

        // Random phase.
        lvl = 0;
        for (int c = 0; c < 3000; c++) begin
            #1;
            pc_in         = PC_W'($urandom);
            flag_register = 3'($urandom_range(0, 7));
            if (lvl == 0 && $urandom_range(0, 199) == 0) lvl = $urandom_range(2, 12);
            int_req = (lvl > 0) || ($urandom_range(0, 29) == 0);
            if (lvl > 0) lvl--;
            rti_decoded = ($urandom_range(0, 7) == 0) && (mstack.size() >= 3);
            @(negedge clk);
        end
        #1 int_req = 1'b0; rti_decoded = 1'b0;
        repeat (40) @(negedge clk);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/interrupt_flag_ctrl.md
Name: interrupt_flag_ctrl

Overview:
- Sequencer that saves and restores machine context (return PC and the ALU's 3-bit {C,N,Z} flag register) on the data stack around interrupts.
- Sits beside the memory stage of the 16-bit pipelined processor.
- On interrupt: stalls and flushes the front end, pushes PC and flags, then redirects fetch to the handler vector.
- On RTI: pops flags and PC, and hands the popped flags to the execute-stage ALU through its flag_regsel/conditions_from_memory_pop inputs.

Parameters:
- PC_W, 32, program-counter width; pushed as two 16-bit words. Legal values 17..32.
- INT_VECTOR, 32'h0000_0020, handler start address loaded on interrupt entry.
- DRAIN_CYCLES, 3, cycles waited so in-flight EX/MEM/WB instructions retire before any push. Legal values 1..7.

Ports:
- clk  in  1  single clock; all state changes on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- int_req  in  1  external interrupt request; level or single-cycle pulse, latched internally.
- rti_decoded  in  1  one-cycle strobe: RTI instruction in decode.
- pc_in  in  PC_W  PC of the next unexecuted instruction (return address).
- flag_register  in  3  current ALU flags {C,N,Z}.
- mem_rdata  in  16  stack read data; valid the cycle after a pop request.
- mem_req  out  1  stack access this cycle.
- mem_we  out  1  1 = push (write, SP decrements after); 0 = pop (SP increments before read).
- mem_wdata  out  16  push data.
- stall  out  1  freeze PC and IF/ID.
- flush  out  1  squash IF/ID contents.
- pc_load  out  1  one-cycle PC override.
- pc_load_value  out  PC_W  PC override value.
- flag_regsel  out  1  1 = ALU flag register takes conditions_from_memory_pop at the next negedge.
- conditions_from_memory_pop  out  3  popped flags.
- int_ack  out  1  one-cycle pulse when the handler vector is loaded.
- busy  out  1  FSM not IDLE.

Behaviour:
- Reset (asynchronous, any state): FSM -> IDLE; pending latch cleared; all outputs 0; pc_load_value and conditions_from_memory_pop = 0.
- pending latch:
  - Set on any cycle int_req=1.
  - Cleared only in the cycle the FSM leaves IDLE for DRAIN.
  - A request arriving while busy stays pending. There is no nesting.
- IDLE, priority:
  - rti_decoded -> POP_FLG.
  - Otherwise pending -> DRAIN: capture ret_pc <= pc_in, assert flush that cycle.
  - Simultaneous RTI and pending: RTI wins; the interrupt is taken on the first IDLE cycle after return.
- DRAIN: counter counts DRAIN_CYCLES cycles. On the last cycle, capture saved_flags <= flag_register, then -> PUSH_PCH.
- PUSH_PCH: mem_req=1, mem_we=1, mem_wdata = ret_pc[PC_W-1:16], zero-extended. -> PUSH_PCL.
- PUSH_PCL: push ret_pc[15:0]. -> PUSH_FLG.
- PUSH_FLG: push {13'b0, saved_flags}. -> LOAD_VEC.
- LOAD_VEC: pc_load=1, pc_load_value=INT_VECTOR, int_ack=1. -> IDLE.
  - Interrupt latency from pending-set: 1 + DRAIN_CYCLES + 4 cycles.
- POP_FLG: pop request (mem_req=1, mem_we=0). -> POP_PCL.
- POP_PCL: pop request. mem_rdata[2:0] is driven on conditions_from_memory_pop with flag_regsel=1 for this cycle only. -> POP_PCH.
- POP_PCH: pop request; latch lo <= mem_rdata. -> RTI_LOAD.
- RTI_LOAD: pc_load=1, pc_load_value = {mem_rdata[PC_W-17:0], lo}. -> IDLE.
- stall=1 in every state except IDLE. busy equals stall.
- int_req and rti_decoded are ignored while busy, except for setting the pending latch.
- Stack order, top-down after entry: flags, PC_lo, PC_hi. Pops are exactly the reverse of pushes.
- All outputs are registered-state decodes (Moore). No combinational path from inputs to outputs except mem_rdata -> conditions_from_memory_pop / pc_load_value.

Decomposition:
- Shared package riscp_pkg holds:
  - ictl_state_t enum: IDLE, DRAIN, PUSH_PCH, PUSH_PCL, PUSH_FLG, LOAD_VEC, POP_FLG, POP_PCL, POP_PCH, RTI_LOAD.
  - FLAG_W=3.
  - Flag bit indices: C=2, N=1, Z=0.
- Single module; no sub-module is needed. The drain counter and pending latch stay inline.

Test Plan:
- Reset mid-push (assert rst_n=0 in PUSH_PCL) -> all outputs 0 immediately, busy=0; after release an idle cycle produces no mem_req.
- pc_in=32'h0001_0A4C, flags=3'b101, int_req pulse -> flush 1 cycle, 3 drain cycles, pushes 16'h0001, 16'h0A4C, 16'h0005, then pc_load=1 with 32'h0000_0020 and int_ack=1. Total 8 cycles from the request.
- RTI with mem_rdata sequence 16'h0006, 16'h1234, 16'h0002 -> flag_regsel=1 with conditions=3'b110 for exactly one cycle; then pc_load with 32'h0002_1234.
- int_req during RTI sequence -> not lost; DRAIN entered on the cycle after RTI_LOAD returns to IDLE.
- rti_decoded and pending interrupt in the same IDLE cycle -> POP_FLG taken first; the interrupt is serviced afterwards.
- Back-to-back interrupt then RTI round trip -> popped PC and flags equal the pushed values bit-exactly.
